score_tracker: RTL

Game-side score engine for meteor dodge. It accumulates the current score from dodge events and survival ticks, and tracks game state, high score and difficulty level. Its 16-bit score output feeds the binary-to-decimal digit converter directly, so the score is held within 0..MAX_SCORE at all times. The level output goes to the meteor spawner.

---
 rtl/score_tracker_pkg.sv | 16 +
 rtl/score_tracker_if.sv | 26 ++
 rtl/score_tracker_tick_divider.sv | 39 +++
 rtl/score_tracker.sv | 123 ++++++++++++
 4 files changed

// File: rtl/score_tracker_pkg.sv
// Shared types and widths for the meteor-dodge score path.
// Pure declarations; no logic, no latency, no backpressure.
// The display path reuses MAX_SCORE_DEF as its 4-digit ceiling.
package score_pkg;

  localparam int SCORE_W       = 16;
  localparam int LEVEL_W       = 3;
  localparam int MAX_SCORE_DEF = 9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

endpackage

// File: rtl/score_tracker_if.sv
// Game-event pulses in, score/level/status out.
// Outputs are registered in the tracker; pulses are single-cycle.
// No backpressure: every pulse is consumed in the cycle it is seen.
interface score_tracker_if;
  import score_pkg::*;

  logic               game_start;
  logic               game_over;
  logic               dodge_pulse;
  logic               tick;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic [LEVEL_W-1:0] level;
  logic               playing;
  logic               new_high;

  modport master (
    output game_start, game_over, dodge_pulse, tick,
    input  score, high_score, level, playing, new_high
  );

  modport slave (
    input  game_start, game_over, dodge_pulse, tick,
    output score, high_score, level, playing, new_high
  );
endinterface

// File: rtl/score_tracker_tick_divider.sv
// Modulo-TICKS_PER_POINT tick counter producing one survival point per wrap.
// point_pulse is combinational in the wrapping tick cycle; the count updates next edge.
// No backpressure: enable is taken every cycle it is high.
module tick_divider #(
  parameter int TICKS_PER_POINT = 60
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic point_pulse
);

  localparam int CNT_W = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_POINT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign point_pulse = enable && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = point_pulse ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Score engine: accumulates dodge/survival points, tracks level, high score and game state.
// 1-cycle latency from any pulse to its effect on the registered outputs.
// No backpressure; game_over pre-empts same-cycle dodge/tick while playing.
module score_tracker
  import score_pkg::*;
#(
  parameter int MAX_SCORE        = MAX_SCORE_DEF,
  parameter int DODGE_POINTS     = 10,
  parameter int TICKS_PER_POINT  = 60,
  parameter int DODGES_PER_LEVEL = 8,
  parameter int MAX_LEVEL        = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  score_tracker_if.slave  bus
);

  localparam int DCNT_W = (DODGES_PER_LEVEL > 1) ? $clog2(DODGES_PER_LEVEL) : 1;
  localparam logic [DCNT_W-1:0]  DCNT_LAST = DCNT_W'(DODGES_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(MAX_LEVEL);
  localparam logic [SCORE_W:0]   SCORE_CAP = (SCORE_W+1)'(MAX_SCORE);

  state_e             state_q,    state_d;
  logic [SCORE_W-1:0] score_q,    score_d;
  logic [SCORE_W-1:0] high_q,     high_d;
  logic [LEVEL_W-1:0] level_q,    level_d;
  logic [DCNT_W-1:0]  dcnt_q,     dcnt_d;
  logic               new_high_q, new_high_d;

  logic               in_play;
  logic               div_clear;
  logic               div_enable;
  logic               point_pulse;
  logic [SCORE_W:0]   add_v;
  logic [SCORE_W:0]   sum_v;

  assign in_play    = (state_q == ST_PLAY);
  // A tick in the game_over cycle is dropped, so it must not advance the divider either.
  assign div_enable = bus.tick && in_play && !bus.game_over;
  assign div_clear  = bus.game_start && !in_play;

  tick_divider #(
    .TICKS_PER_POINT (TICKS_PER_POINT)
  ) u_tick_divider (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (div_clear),
    .enable      (div_enable),
    .point_pulse (point_pulse)
  );

  always_comb begin
    add_v = '0;
    if (bus.dodge_pulse) add_v = add_v + (SCORE_W+1)'(DODGE_POINTS);
    if (point_pulse)     add_v = add_v + 1'b1;
    sum_v = {1'b0, score_q} + add_v;
  end

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    level_d    = level_q;
    dcnt_d     = dcnt_q;
    new_high_d = new_high_q;

    unique case (state_q)
      ST_PLAY: begin
        if (bus.game_over) begin
          state_d = ST_OVER;
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end
        end else begin
          score_d = (sum_v > SCORE_CAP) ? SCORE_W'(MAX_SCORE) : sum_v[SCORE_W-1:0];
          if (bus.dodge_pulse) begin
            if (dcnt_q == DCNT_LAST) begin
              dcnt_d = '0;
              if (level_q != LEVEL_TOP) level_d = level_q + 1'b1;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        if (bus.game_start) begin
          state_d    = ST_PLAY;
          score_d    = '0;
          level_d    = '0;
          dcnt_d     = '0;
          new_high_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      high_q     <= '0;
      level_q    <= '0;
      dcnt_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      level_q    <= level_d;
      dcnt_q     <= dcnt_d;
      new_high_q <= new_high_d;
    end
  end

  assign bus.score      = score_q;
  assign bus.high_score = high_q;
  assign bus.level      = level_q;
  assign bus.playing    = in_play;
  assign bus.new_high   = new_high_q;

endmodule
